// File: rtl/i3c_bus_model.sv
// Open-drain I3C/I2C bus model: wired-AND of agent drives with pull-up rise delay,
// plus START/rSTART/STOP detection, bus-free timing and per-agent arbitration flags.
module i3c_bus_model #(
  parameter int unsigned NUM_AGENTS      = 2,
  parameter int unsigned RISE_CYCLES     = 2,
  parameter int unsigned BUS_FREE_CYCLES = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_AGENTS-1:0] sda_i,
  input  logic [NUM_AGENTS-1:0] scl_i,
  input  logic [NUM_AGENTS-1:0] arb_lost_clr_i,
  output logic                  sda_o,
  output logic                  scl_o,
  output logic                  start_o,
  output logic                  rstart_o,
  output logic                  stop_o,
  output logic                  bus_busy_o,
  output logic                  bus_free_o,
  output logic [NUM_AGENTS-1:0] arb_lost_o
);

  typedef enum logic {
    BUS_IDLE,
    BUS_BUSY
  } bus_state_e;

  bus_state_e  bus_state;
  logic        sda_and;
  logic        scl_and;
  logic [3:0]  sda_rise_cnt;
  logic [3:0]  scl_rise_cnt;
  logic        sda_q;
  logic        scl_q;
  logic        start_det;
  logic        stop_det;
  logic        scl_rise;
  logic [7:0]  free_cnt;

  always_comb begin
    sda_and = &sda_i;
    scl_and = &scl_i;
  end

  // A released line stays low until RISE_CYCLES+1 consecutive released samples.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sda_o        <= 1'b1;
      sda_rise_cnt <= '0;
    end else if (!sda_and) begin
      sda_o        <= 1'b0;
      sda_rise_cnt <= '0;
    end else if (!sda_o) begin
      if (sda_rise_cnt == 4'(RISE_CYCLES)) begin
        sda_o        <= 1'b1;
        sda_rise_cnt <= '0;
      end else begin
        sda_rise_cnt <= sda_rise_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_o        <= 1'b1;
      scl_rise_cnt <= '0;
    end else if (!scl_and) begin
      scl_o        <= 1'b0;
      scl_rise_cnt <= '0;
    end else if (!scl_o) begin
      if (scl_rise_cnt == 4'(RISE_CYCLES)) begin
        scl_o        <= 1'b1;
        scl_rise_cnt <= '0;
      end else begin
        scl_rise_cnt <= scl_rise_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    start_det = scl_o & scl_q & sda_q & ~sda_o;
    stop_det  = scl_o & scl_q & ~sda_q & sda_o;
    scl_rise  = scl_o & ~scl_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sda_q     <= 1'b1;
      scl_q     <= 1'b1;
      start_o   <= 1'b0;
      rstart_o  <= 1'b0;
      stop_o    <= 1'b0;
      bus_state <= BUS_IDLE;
    end else begin
      sda_q    <= sda_o;
      scl_q    <= scl_o;
      start_o  <= start_det & (bus_state == BUS_IDLE);
      rstart_o <= start_det & (bus_state == BUS_BUSY);
      stop_o   <= stop_det;
      if (start_det) begin
        bus_state <= BUS_BUSY;
      end else if (stop_det) begin
        bus_state <= BUS_IDLE;
      end
    end
  end

  assign bus_busy_o = (bus_state == BUS_BUSY);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      free_cnt <= '0;
    end else if (sda_o & scl_o & ~bus_busy_o) begin
      if (free_cnt != '1) begin
        free_cnt <= free_cnt + 8'd1;
      end
    end else begin
      free_cnt <= '0;
    end
  end

  assign bus_free_o = (free_cnt >= 8'(BUS_FREE_CYCLES));

  // Set takes priority over clear; a STOP clears every agent's flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arb_lost_o <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_AGENTS; k++) begin
        if (scl_rise & bus_busy_o & sda_i[k] & ~sda_o) begin
          arb_lost_o[k] <= 1'b1;
        end else if (arb_lost_clr_i[k] | stop_det) begin
          arb_lost_o[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_i3c_bus_model.sv
// Bench for i3c_bus_model: directed test-plan scenarios plus randomized drives,
// checked every cycle against a behavioural model of the bus rules.
module tb_i3c_bus_model;

  localparam int NA = 3;
  localparam int RC = 2;
  localparam int BF = 8;
  localparam int RUN_MAX = 1000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NA-1:0] sda_d;
  logic [NA-1:0] scl_d;
  logic [NA-1:0] clr_d;
  logic          sda_o, scl_o, start_o, rstart_o, stop_o, bus_busy_o, bus_free_o;
  logic [NA-1:0] arb_lost_o;

  int n_vec = 0;
  int n_err = 0;
  int n_start = 0;
  int n_rstart = 0;
  int n_stop = 0;

  // Model state: a line reads high once it has been released for more than RC samples.
  int          run_sda, run_scl, free_run;
  bit          m_sda_q, m_scl_q, m_start, m_rstart, m_stop, m_busy;
  bit [NA-1:0] m_arb;

  always #5 clk = ~clk;

  i3c_bus_model #(
    .NUM_AGENTS      (NA),
    .RISE_CYCLES     (RC),
    .BUS_FREE_CYCLES (BF)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .sda_i          (sda_d),
    .scl_i          (scl_d),
    .arb_lost_clr_i (clr_d),
    .sda_o          (sda_o),
    .scl_o          (scl_o),
    .start_o        (start_o),
    .rstart_o       (rstart_o),
    .stop_o         (stop_o),
    .bus_busy_o     (bus_busy_o),
    .bus_free_o     (bus_free_o),
    .arb_lost_o     (arb_lost_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_sda  = RUN_MAX;
      run_scl  = RUN_MAX;
      free_run = 0;
      m_sda_q  = 1'b1;
      m_scl_q  = 1'b1;
      m_start  = 1'b0;
      m_rstart = 1'b0;
      m_stop   = 1'b0;
      m_busy   = 1'b0;
      m_arb    = '0;
    end else begin
      bit s, c, st, sp;
      s  = run_sda > RC;
      c  = run_scl > RC;
      st = c && m_scl_q && m_sda_q && !s;
      sp = c && m_scl_q && !m_sda_q && s;
      free_run = (s && c && !m_busy) ? free_run + 1 : 0;
      for (int k = 0; k < NA; k++) begin
        if (c && !m_scl_q && m_busy && sda_d[k] && !s) m_arb[k] = 1'b1;
        else if (clr_d[k] || sp) m_arb[k] = 1'b0;
      end
      m_start  = st && !m_busy;
      m_rstart = st && m_busy;
      m_stop   = sp;
      if (st) m_busy = 1'b1;
      else if (sp) m_busy = 1'b0;
      m_sda_q = s;
      m_scl_q = c;
      run_sda = (&sda_d) ? ((run_sda < RUN_MAX) ? run_sda + 1 : RUN_MAX) : 0;
      run_scl = (&scl_d) ? ((run_scl < RUN_MAX) ? run_scl + 1 : RUN_MAX) : 0;
    end
  end

  always @(negedge clk) begin
    chk("sda_o",      32'(sda_o),      32'(run_sda > RC));
    chk("scl_o",      32'(scl_o),      32'(run_scl > RC));
    chk("start_o",    32'(start_o),    32'(m_start));
    chk("rstart_o",   32'(rstart_o),   32'(m_rstart));
    chk("stop_o",     32'(stop_o),     32'(m_stop));
    chk("bus_busy_o", 32'(bus_busy_o), 32'(m_busy));
    chk("bus_free_o", 32'(bus_free_o), 32'(free_run >= BF));
    chk("arb_lost_o", 32'(arb_lost_o), 32'(m_arb));
    if (start_o)  n_start++;
    if (rstart_o) n_rstart++;
    if (stop_o)   n_stop++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int b_start, b_rstart, b_stop, hold_sda, hold_scl;

    // Reset and idle
    rst_n = 1'b0; sda_d = '1; scl_d = '1; clr_d = '0;
    tick(3);
    chk("rst_sda", 32'(sda_o), 32'd1);
    chk("rst_scl", 32'(scl_o), 32'd1);
    chk("rst_free", 32'(bus_free_o), 32'd0);
    chk("rst_arb", 32'(arb_lost_o), 32'd0);
    rst_n = 1'b1;
    tick(7);
    chk("free_edge7", 32'(bus_free_o), 32'd0);
    tick(1);
    chk("free_edge8", 32'(bus_free_o), 32'd1);
    tick(4);

    // Wired-AND, fall and rise latency
    sda_d = 3'b101;
    tick(1);
    chk("sda_fall", 32'(sda_o), 32'd0);
    tick(4);
    sda_d = 3'b111;
    tick(2);
    chk("sda_rise_early", 32'(sda_o), 32'd0);
    tick(1);
    chk("sda_rise", 32'(sda_o), 32'd1);
    tick(10);

    // Re-pull during the rise count
    sda_d = 3'b101;
    tick(3);
    sda_d = 3'b111;
    tick(2);
    sda_d = 3'b011;
    tick(1);
    chk("repull_low", 32'(sda_o), 32'd0);
    sda_d = 3'b111;
    tick(2);
    chk("repull_early", 32'(sda_o), 32'd0);
    tick(1);
    chk("repull_rise", 32'(sda_o), 32'd1);
    tick(12);

    // START, repeated START, STOP
    b_start = n_start; b_rstart = n_rstart; b_stop = n_stop;
    sda_d = 3'b110;
    tick(1);
    chk("st_no_pulse_yet", 32'(start_o), 32'd0);
    tick(1);
    chk("st_pulse", 32'(start_o), 32'd1);
    chk("st_busy", 32'(bus_busy_o), 32'd1);
    tick(4);
    scl_d = 3'b110; tick(6);
    sda_d = 3'b111; tick(6);
    scl_d = 3'b111; tick(6);
    sda_d = 3'b110; tick(6);
    chk("rs_busy", 32'(bus_busy_o), 32'd1);
    chk("rs_free", 32'(bus_free_o), 32'd0);
    scl_d = 3'b110; tick(6);
    scl_d = 3'b111; tick(6);
    sda_d = 3'b111;
    tick(3);
    chk("sp_no_pulse_yet", 32'(stop_o), 32'd0);
    tick(1);
    chk("sp_pulse", 32'(stop_o), 32'd1);
    chk("sp_busy", 32'(bus_busy_o), 32'd0);
    tick(2);
    chk("n_start", 32'(n_start - b_start), 32'd1);
    chk("n_rstart", 32'(n_rstart - b_rstart), 32'd1);
    chk("n_stop", 32'(n_stop - b_stop), 32'd1);
    tick(10);

    // Arbitration loss
    sda_d = 3'b110; tick(6);
    scl_d = 3'b110; tick(6);
    sda_d = 3'b001; tick(6);
    scl_d = 3'b111;
    tick(3);
    chk("arb_before", 32'(arb_lost_o), 32'd0);
    tick(1);
    chk("arb_set", 32'(arb_lost_o), 32'b001);
    tick(5);
    chk("arb_sticky", 32'(arb_lost_o), 32'b001);
    scl_d = 3'b110; tick(6);
    scl_d = 3'b111; tick(3);
    clr_d = 3'b001;
    tick(1);
    chk("arb_set_wins", 32'(arb_lost_o), 32'b001);
    tick(1);
    chk("arb_clr", 32'(arb_lost_o), 32'b000);
    clr_d = 3'b000;
    scl_d = 3'b110; tick(6);
    scl_d = 3'b111; tick(4);
    chk("arb_reset", 32'(arb_lost_o), 32'b001);
    sda_d = 3'b111;
    tick(4);
    chk("arb_stop_pulse", 32'(stop_o), 32'd1);
    chk("arb_stop_clr", 32'(arb_lost_o), 32'b000);
    tick(10);

    // Clock stretching
    b_start = n_start; b_rstart = n_rstart; b_stop = n_stop;
    scl_d = 3'b101;
    tick(1);
    for (int i = 0; i < 20; i++) begin
      chk("stretch_low", 32'(scl_o), 32'd0);
      tick(1);
    end
    scl_d = 3'b111;
    tick(2);
    chk("stretch_early", 32'(scl_o), 32'd0);
    tick(1);
    chk("stretch_rise", 32'(scl_o), 32'd1);
    tick(3);
    chk("stretch_pulses", 32'((n_start - b_start) + (n_rstart - b_rstart) + (n_stop - b_stop)), 32'd0);
    tick(10);

    // Reset mid-transfer
    sda_d = 3'b110; tick(6);
    chk("mid_busy", 32'(bus_busy_o), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_sda", 32'(sda_o), 32'd1);
    chk("mid_scl", 32'(scl_o), 32'd1);
    chk("mid_busy_clr", 32'(bus_busy_o), 32'd0);
    chk("mid_stop", 32'(stop_o), 32'd0);
    chk("mid_start", 32'(start_o), 32'd0);
    tick(2);
    sda_d = 3'b111;
    rst_n = 1'b1;
    tick(7);
    chk("mid_free7", 32'(bus_free_o), 32'd0);
    tick(1);
    chk("mid_free8", 32'(bus_free_o), 32'd1);

    // Randomized drives
    hold_sda = 0; hold_scl = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hold_sda == 0) begin
        for (int k = 0; k < NA; k++) sda_d[k] = ($urandom_range(3) != 0);
        hold_sda = $urandom_range(1, 8);
      end
      if (hold_scl == 0) begin
        for (int k = 0; k < NA; k++) scl_d[k] = ($urandom_range(3) != 0);
        hold_scl = $urandom_range(1, 8);
      end
      hold_sda--;
      hold_scl--;
      for (int k = 0; k < NA; k++) clr_d[k] = ($urandom_range(7) == 0);
      rst_n = ($urandom_range(399) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
